// File: rtl/line_fill_pkg.sv
// rtl/line_fill_pkg.sv - shared states and line geometry for the line fill unit
package line_fill_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB        = 3'd1,
    FILL      = 3'd2,
    FILL_LAST = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int LINE_WORDS    = 8;
  localparam int LINE_BITS     = 256;
  localparam int WORD_OFF_BITS = 3;
  localparam int LINE_OFF_BITS = 5;

endpackage

// File: rtl/line_fill_unit.sv
// rtl/line_fill_unit.sv - victim write-back and line refill engine between cache and word BRAM
module line_fill_unit
  import line_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_fill,
  input  logic                              req_wb,
  input  logic [ADDR_WIDTH-LINE_OFF_BITS-1:0] req_fill_line,
  input  logic [ADDR_WIDTH-LINE_OFF_BITS-1:0] req_wb_line,
  input  logic [LINE_BITS-1:0]              req_wb_data,
  output logic [LINE_BITS-1:0]              fill_data,
  output logic                              done,
  output logic [ADDR_WIDTH-3:0]             mem_addr,
  output logic                              mem_re,
  output logic                              mem_we,
  output logic [31:0]                       mem_wdata,
  input  logic [31:0]                       mem_rdata
);

  localparam int LINE_AW = ADDR_WIDTH - LINE_OFF_BITS;
  localparam logic [WORD_OFF_BITS-1:0] LAST_WORD = WORD_OFF_BITS'(LINE_WORDS - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [WORD_OFF_BITS-1:0]   word_cnt;
  logic [WORD_OFF_BITS-1:0]   cap_idx;
  logic                       rd_pending;
  logic                       fill_l;
  logic                       wb_l;
  logic [LINE_AW-1:0]         fill_line_l;
  logic [LINE_AW-1:0]         wb_line_l;
  logic [LINE_BITS-1:0]       wb_data_l;
  logic                       accept;

  assign accept = req_ready && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_wb)        state_nxt = WB;
          else if (req_fill) state_nxt = FILL;
          else               state_nxt = DONE;
        end
      end
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = {wb_line_l, word_cnt};
        mem_wdata = wb_data_l[{word_cnt, 5'b0} +: 32];
        if (word_cnt == LAST_WORD) state_nxt = fill_l ? FILL : DONE;
      end
      FILL: begin
        mem_re   = 1'b1;
        mem_addr = {fill_line_l, word_cnt};
        if (word_cnt == LAST_WORD) state_nxt = FILL_LAST;
      end
      FILL_LAST: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // BRAM data lags the read by one cycle, so the word index travels with rd_pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt    <= '0;
      cap_idx     <= '0;
      rd_pending  <= 1'b0;
      fill_l      <= 1'b0;
      wb_l        <= 1'b0;
      fill_line_l <= '0;
      wb_line_l   <= '0;
      wb_data_l   <= '0;
      fill_data   <= '0;
    end else begin
      if (accept) begin
        fill_l      <= req_fill;
        wb_l        <= req_wb;
        fill_line_l <= req_fill_line;
        wb_line_l   <= req_wb_line;
        wb_data_l   <= req_wb_data;
      end
      if (state == WB || state == FILL) begin
        word_cnt <= word_cnt + 1'b1;
      end
      rd_pending <= (state == FILL);
      cap_idx    <= word_cnt;
      if (rd_pending) begin
        fill_data[{cap_idx, 5'b0} +: 32] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// tb/tb_line_fill_unit.sv - directed self-checking bench for line_fill_unit
module tb_line_fill_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_fill;
  logic         req_wb;
  logic [8:0]   req_fill_line;
  logic [8:0]   req_wb_line;
  logic [255:0] req_wb_data;
  logic [255:0] fill_data;
  logic         done;
  logic [11:0]  mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  logic [31:0]  bram [0:4095];
  logic         tb_we;
  logic [11:0]  tb_addr;
  logic [31:0]  tb_wdata;

  int vectors = 0;
  int errs    = 0;

  line_fill_unit #(.ADDR_WIDTH(14)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fill      (req_fill),
    .req_wb        (req_wb),
    .req_fill_line (req_fill_line),
    .req_wb_line   (req_wb_line),
    .req_wb_data   (req_wb_data),
    .fill_data     (fill_data),
    .done          (done),
    .mem_addr      (mem_addr),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port BRAM, one-cycle read latency; tb port only used for preload.
  always @(posedge clk) begin
    if (mem_we)     bram[mem_addr] <= mem_wdata;
    else if (tb_we) bram[tb_addr]  <= tb_wdata;
    if (mem_re)     mem_rdata      <= bram[mem_addr];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic f, input logic w, input logic [8:0] fl, input logic [8:0] wl,
                         input logic [255:0] wd, input int exp_done, input bit hold, input string name);
    int          off;
    logic        e_we, e_re;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    req_valid     = 1'b1;
    req_fill      = f;
    req_wb        = w;
    req_fill_line = fl;
    req_wb_line   = wl;
    req_wb_data   = wd;
    chk({name, ".ready_idle"}, req_ready, 1'b1);
    off = w ? 8 : 0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (!hold) begin
        req_valid     = 1'b0;
        req_fill      = ~f;
        req_wb        = ~w;
        req_fill_line = ~fl;
        req_wb_line   = ~wl;
        req_wb_data   = ~wd;
      end
      e_we    = w && (c <= 8);
      e_re    = f && (c > off) && (c <= off + 8);
      e_addr  = e_we ? {wl, 3'(c - 1)} : (e_re ? {fl, 3'(c - off - 1)} : 12'h000);
      e_wdata = e_we ? wd[(c - 1) * 32 +: 32] : 32'h0;
      chk($sformatf("%s.c%0d.done", name, c), done, (c == exp_done));
      chk($sformatf("%s.c%0d.ready", name, c), req_ready, (c > exp_done));
      chk($sformatf("%s.c%0d.we", name, c), mem_we, e_we);
      chk($sformatf("%s.c%0d.re", name, c), mem_re, e_re);
      chk($sformatf("%s.c%0d.addr", name, c), mem_addr, e_addr);
      chk($sformatf("%s.c%0d.wdata", name, c), mem_wdata, e_wdata);
    end
  endtask

  initial begin
    logic [255:0] line_a, line_b, line_c, zero_line;
    for (int k = 0; k < 8; k++) begin
      line_a[k*32 +: 32] = 32'h1000_0000 + k;
      line_b[k*32 +: 32] = 32'hA5A5_0000 + k;
      line_c[k*32 +: 32] = 32'hC0DE_0000 + k * 32'h0101;
    end
    zero_line     = '0;
    rst_n         = 1'b0;
    req_valid     = 1'b1;
    req_fill      = 1'b1;
    req_wb        = 1'b1;
    req_fill_line = 9'h008;
    req_wb_line   = 9'h001;
    req_wb_data   = line_b;
    tb_we         = 1'b0;
    tb_addr       = '0;
    tb_wdata      = '0;

    // Reset state, with a request held that must be ignored; preload line 0x008.
    @(negedge clk);
    chk("rst.ready", req_ready, 1'b1);
    chk("rst.done", done, 1'b0);
    chk("rst.re", mem_re, 1'b0);
    chk("rst.we", mem_we, 1'b0);
    chk("rst.addr", mem_addr, 12'h000);
    chk("rst.wdata", mem_wdata, 32'h0);
    chk("rst.fill_data", fill_data, zero_line);
    for (int k = 0; k < 8; k++) begin
      tb_we    = 1'b1;
      tb_addr  = 12'h040 + 12'(k);
      tb_wdata = 32'h1000_0000 + k;
      @(negedge clk);
      chk($sformatf("rst.idle%0d", k), mem_re | mem_we | done, 1'b0);
    end
    tb_we     = 1'b0;
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    run_req(1'b1, 1'b0, 9'h008, 9'h000, '0, 10, 1'b0, "fill");
    chk("fill.data", fill_data, line_a);

    run_req(1'b0, 1'b1, 9'h000, 9'h001, line_b, 9, 1'b0, "wb");
    chk("wb.fill_data_kept", fill_data, line_a);

    run_req(1'b1, 1'b1, 9'h003, 9'h003, line_c, 18, 1'b0, "wbfill");
    chk("wbfill.data", fill_data, line_c);

    run_req(1'b0, 1'b0, 9'h0AA, 9'h055, line_a, 1, 1'b0, "null");
    chk("null.fill_data_kept", fill_data, line_c);

    // Back-to-back with req_valid held high across both requests.
    run_req(1'b1, 1'b0, 9'h001, 9'h000, '0, 10, 1'b1, "b2b1");
    chk("b2b1.data", fill_data, line_b);
    run_req(1'b1, 1'b0, 9'h008, 9'h000, '0, 10, 1'b0, "b2b2");
    chk("b2b2.data", fill_data, line_a);

    // Reset after the fourth read of a fill.
    req_valid     = 1'b1;
    req_fill      = 1'b1;
    req_wb        = 1'b0;
    req_fill_line = 9'h003;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("rstmid.re_before", mem_re, 1'b1);
    chk("rstmid.addr_before", mem_addr, 12'h01C);
    rst_n = 1'b0;
    #1;
    chk("rstmid.re", mem_re, 1'b0);
    chk("rstmid.addr", mem_addr, 12'h000);
    chk("rstmid.fill_data", fill_data, zero_line);
    chk("rstmid.ready", req_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid.hold%0d.done", c), done, 1'b0);
      chk($sformatf("rstmid.hold%0d.re", c), mem_re, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.post_done", done, 1'b0);
    run_req(1'b1, 1'b0, 9'h003, 9'h000, '0, 10, 1'b0, "refill");
    chk("refill.data", fill_data, line_c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
